// File: rtl/ram_access_ctrl_pkg.sv
// rtl/ram_access_ctrl_pkg.sv - shared types and helpers for the RAM load/store sequencer
package ram_access_ctrl_pkg;

    typedef enum logic [1:0] {
        RAM_MASK_B = 2'd0,
        RAM_MASK_H = 2'd1,
        RAM_MASK_W = 2'd2
    } ram_mask_e;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        WAIT  = 3'd2,
        MERGE = 3'd3,
        WR    = 3'd4,
        RESP  = 3'd5
    } ram_ctrl_state_e;

    function automatic logic is_misaligned(ram_mask_e mask, logic [1:0] lane);
        case (mask)
            RAM_MASK_H: return lane[0];
            RAM_MASK_W: return |lane;
            default:    return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/ram_access_ctrl_mask.sv
// rtl/ram_access_ctrl_mask.sv - zero-extends the low byte/half of a word, passes W through
module ram_access_ctrl_mask
    import ram_access_ctrl_pkg::*;
(
    input  logic [31:0] word,
    input  ram_mask_e   mask,
    output logic [31:0] masked
);

    always_comb begin
        masked = word;
        case (mask)
            RAM_MASK_B: masked = {24'd0, word[7:0]};
            RAM_MASK_H: masked = {16'd0, word[15:0]};
            default:    masked = word;
        endcase
    end

endmodule

// File: rtl/ram_access_ctrl.sv
// rtl/ram_access_ctrl.sv - byte/half/word load-store sequencer for a 32-bit word RAM without byte enables
module ram_access_ctrl
    import ram_access_ctrl_pkg::*;
#(
    parameter int ADDR_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W+1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  ram_mask_e         req_mask,
    input  logic              req_unsigned,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_re,
    output logic              ram_we,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    localparam int CNT_W = $clog2(RD_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LATENCY);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    ram_ctrl_state_e state, state_next;

    logic [ADDR_W+1:0] addr_q;
    logic              we_q;
    logic [15:0]       wdata_q;
    ram_mask_e         mask_q;
    logic              uns_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [31:0]       word_q;
    logic [31:0]       wr_word_q;
    logic [31:0]       rdata_q;
    logic              err_q;

    logic              accept;
    logic              req_misaligned;
    logic [31:0]       lane_word;
    logic [31:0]       zext_word;
    logic [31:0]       load_word;
    logic [31:0]       merged_word;

    assign accept         = (state == IDLE) && req_valid;
    assign req_misaligned = is_misaligned(req_mask, req_addr[1:0]);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stores leave WAIT on the data cycle; loads take one more WAIT cycle to register the extended result.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    if (req_misaligned)
                        state_next = RESP;
                    else if (req_we && req_mask == RAM_MASK_W)
                        state_next = WR;
                    else
                        state_next = RD;
                end
            end
            RD:    state_next = WAIT;
            WAIT: begin
                if (we_q) begin
                    if (cnt_q == CNT_ONE)
                        state_next = MERGE;
                end else if (cnt_q == '0) begin
                    state_next = RESP;
                end
            end
            MERGE: state_next = WR;
            WR:    state_next = RESP;
            RESP: begin
                if (rsp_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            mask_q    <= RAM_MASK_W;
            uns_q     <= 1'b0;
            cnt_q     <= '0;
            word_q    <= '0;
            wr_word_q <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= req_addr;
                we_q    <= req_we;
                wdata_q <= req_wdata[15:0];
                mask_q  <= req_mask;
                uns_q   <= req_unsigned;
                err_q   <= req_misaligned;
                rdata_q <= '0;
                if (req_we && req_mask == RAM_MASK_W)
                    wr_word_q <= req_wdata;
            end
            if (state == RD)
                cnt_q <= CNT_LOAD;
            if (state == WAIT) begin
                cnt_q <= cnt_q - CNT_ONE;
                if (cnt_q == CNT_ONE)
                    word_q <= ram_rdata;
                if (!we_q && cnt_q == '0)
                    rdata_q <= load_word;
            end
            if (state == MERGE)
                wr_word_q <= merged_word;
        end
    end

    assign lane_word = word_q >> {addr_q[1:0], 3'b000};

    ram_access_ctrl_mask u_mask (
        .word   (lane_word),
        .mask   (mask_q),
        .masked (zext_word)
    );

    always_comb begin
        load_word = zext_word;
        if (!uns_q) begin
            case (mask_q)
                RAM_MASK_B: load_word = {{24{zext_word[7]}}, zext_word[7:0]};
                RAM_MASK_H: load_word = {{16{zext_word[15]}}, zext_word[15:0]};
                default:    load_word = zext_word;
            endcase
        end
    end

    always_comb begin
        merged_word = word_q;
        if (mask_q == RAM_MASK_H)
            merged_word[{addr_q[1], 4'b0000} +: 16] = wdata_q;
        else
            merged_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign ram_re    = (state == RD);
    assign ram_we    = (state == WR);
    assign ram_addr  = addr_q[ADDR_W+1:2];
    assign ram_wdata = wr_word_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// tb/tb_ram_access_ctrl.sv - directed-vector bench for ram_access_ctrl at read latencies 1 and 3
module tb_ram_access_ctrl;
    import ram_access_ctrl_pkg::*;

    localparam int ADDR_W = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic              req_valid = 1'b0;
    logic              req_we = 1'b0;
    logic [ADDR_W+1:0] req_addr = '0;
    logic [31:0]       req_wdata = '0;
    ram_mask_e         req_mask = RAM_MASK_W;
    logic              req_unsigned = 1'b0;
    logic              rsp_ready = 1'b0;
    logic              sel = 1'b0;

    logic [1:0]              req_ready_v, rsp_valid_v, rsp_err_v, ram_re_v, ram_we_v;
    logic [1:0][31:0]        rsp_rdata_v, ram_wdata_v, ram_rdata_v;
    logic [1:0][ADDR_W-1:0]  ram_addr_v;

    int vectors = 0;
    int miscompares = 0;
    int cur_lat = 1;

    int nre, nwe, both, we_at;
    logic [ADDR_W-1:0] we_addr;
    logic [31:0]       we_data;

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [0:63];
        logic [31:0] dpipe [0:3];
        logic [3:0]  vpipe;

        ram_access_ctrl #(.ADDR_W(ADDR_W), .RD_LATENCY(LAT)) dut (
            .clk          (clk),
            .rst_n        (rst_n),
            .req_valid    (req_valid && (sel == (g != 0))),
            .req_ready    (req_ready_v[g]),
            .req_we       (req_we),
            .req_addr     (req_addr),
            .req_wdata    (req_wdata),
            .req_mask     (req_mask),
            .req_unsigned (req_unsigned),
            .rsp_valid    (rsp_valid_v[g]),
            .rsp_ready    (rsp_ready && (sel == (g != 0))),
            .rsp_rdata    (rsp_rdata_v[g]),
            .rsp_err      (rsp_err_v[g]),
            .ram_addr     (ram_addr_v[g]),
            .ram_re       (ram_re_v[g]),
            .ram_we       (ram_we_v[g]),
            .ram_wdata    (ram_wdata_v[g]),
            .ram_rdata    (ram_rdata_v[g])
        );

        always @(posedge clk) begin
            if (ram_we_v[g])
                mem[ram_addr_v[g][5:0]] <= ram_wdata_v[g];
            dpipe[0] <= mem[ram_addr_v[g][5:0]];
            vpipe[0] <= ram_re_v[g];
            for (int i = 1; i < 4; i++) begin
                dpipe[i] <= dpipe[i-1];
                vpipe[i] <= vpipe[i-1];
            end
        end
        assign ram_rdata_v[g] = vpipe[LAT-1] ? dpipe[LAT-1] : 32'hBAD0_BAD0;
    end

    logic              cur_req_ready, cur_rsp_valid, cur_rsp_err, cur_ram_re, cur_ram_we;
    logic [31:0]       cur_rsp_rdata, cur_ram_wdata;
    logic [ADDR_W-1:0] cur_ram_addr;
    assign cur_req_ready = req_ready_v[sel];
    assign cur_rsp_valid = rsp_valid_v[sel];
    assign cur_rsp_err   = rsp_err_v[sel];
    assign cur_rsp_rdata = rsp_rdata_v[sel];
    assign cur_ram_re    = ram_re_v[sel];
    assign cur_ram_we    = ram_we_v[sel];
    assign cur_ram_wdata = ram_wdata_v[sel];
    assign cur_ram_addr  = ram_addr_v[sel];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL lat%0d %s: got 0x%08h expected 0x%08h", cur_lat, tag, got, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".req_ready"}, 32'(cur_req_ready), 32'd1);
        chk({tag, ".rsp_valid"}, 32'(cur_rsp_valid), 32'd0);
        chk({tag, ".rsp_err"},   32'(cur_rsp_err),   32'd0);
        chk({tag, ".rsp_rdata"}, cur_rsp_rdata,      32'd0);
        chk({tag, ".ram_re"},    32'(cur_ram_re),    32'd0);
        chk({tag, ".ram_we"},    32'(cur_ram_we),    32'd0);
        chk({tag, ".ram_addr"},  32'(cur_ram_addr),  32'd0);
        chk({tag, ".ram_wdata"}, cur_ram_wdata,      32'd0);
    endtask

    task automatic sample(input int k);
        if (cur_ram_re) nre++;
        if (cur_ram_we) begin
            nwe++;
            we_at   = k;
            we_addr = cur_ram_addr;
            we_data = cur_ram_wdata;
        end
        if (cur_ram_re && cur_ram_we) both++;
    endtask

    task automatic xfer(input string tag, input logic we, input logic [ADDR_W+1:0] addr,
                        input logic [31:0] wdata, input ram_mask_e mask, input logic uns,
                        input int hold, input logic [31:0] exp_rdata, input logic exp_err,
                        input int exp_lat, input int exp_re, input int exp_we,
                        input int exp_we_at, input logic [ADDR_W-1:0] exp_we_addr,
                        input logic [31:0] exp_we_data);
        int k;
        logic seen;
        @(negedge clk);
        chk({tag, ".req_ready"}, 32'(cur_req_ready), 32'd1);
        req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
        req_mask = mask; req_unsigned = uns;
        @(posedge clk);
        #1;
        req_valid = 1'b0; req_we = 1'($urandom); req_addr = (ADDR_W+2)'($urandom);
        req_wdata = $urandom; req_unsigned = 1'($urandom);
        k = 0; seen = 1'b0; nre = 0; nwe = 0; both = 0; we_at = -1;
        we_addr = '0; we_data = '0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            sample(k);
            seen = cur_rsp_valid;
        end
        chk({tag, ".latency"}, 32'(seen ? k : -1), 32'(exp_lat));
        for (int h = 0; h < hold; h++) begin
            chk({tag, ".hold_valid"}, 32'(cur_rsp_valid), 32'd1);
            chk({tag, ".hold_rdata"}, cur_rsp_rdata, exp_rdata);
            chk({tag, ".hold_ready"}, 32'(cur_req_ready), 32'd0);
            @(negedge clk);
            k++;
            sample(k);
        end
        chk({tag, ".rdata"}, cur_rsp_rdata, exp_rdata);
        chk({tag, ".err"}, 32'(cur_rsp_err), 32'(exp_err));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk({tag, ".valid_drop"}, 32'(cur_rsp_valid), 32'd0);
        chk({tag, ".n_re"}, 32'(nre), 32'(exp_re));
        chk({tag, ".n_we"}, 32'(nwe), 32'(exp_we));
        chk({tag, ".re_we_overlap"}, 32'(both), 32'd0);
        if (exp_we_at >= 0) begin
            chk({tag, ".we_cycle"}, 32'(we_at), 32'(exp_we_at));
            chk({tag, ".we_addr"}, 32'(we_addr), 32'(exp_we_addr));
            chk({tag, ".we_data"}, we_data, exp_we_data);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        sel = 1'b0;
        #2 chk_reset("reset0");
        sel = 1'b1;
        #1 chk_reset("reset1");
        @(negedge clk);
        rst_n = 1'b1;

        for (int g = 0; g < 2; g++) begin
            int L;
            sel = g[0];
            L = (g == 0) ? 1 : 3;
            cur_lat = L;

            xfer("sw_10",  1'b1, 18'h10, 32'h80FF_7F01, RAM_MASK_W, 1'b0, 0, 32'h0, 1'b0, 2, 0, 1, 1, 16'd4, 32'h80FF_7F01);
            xfer("lb_12",  1'b0, 18'h12, 32'h0, RAM_MASK_B, 1'b0, 0, 32'hFFFF_FFFF, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
            xfer("lbu_12", 1'b0, 18'h12, 32'h0, RAM_MASK_B, 1'b1, 0, 32'h0000_00FF, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
            xfer("lb_13",  1'b0, 18'h13, 32'h0, RAM_MASK_B, 1'b0, 0, 32'hFFFF_FF80, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
            xfer("lbu_13", 1'b0, 18'h13, 32'h0, RAM_MASK_B, 1'b1, 0, 32'h0000_0080, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
            xfer("lh_10",  1'b0, 18'h10, 32'h0, RAM_MASK_H, 1'b0, 0, 32'h0000_7F01, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
            xfer("lh_12",  1'b0, 18'h12, 32'h0, RAM_MASK_H, 1'b0, 0, 32'hFFFF_80FF, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);

            xfer("sw_10b", 1'b1, 18'h10, 32'h1122_3344, RAM_MASK_W, 1'b0, 0, 32'h0, 1'b0, 2, 0, 1, 1, 16'd4, 32'h1122_3344);
            xfer("sb_11",  1'b1, 18'h11, 32'hFFFF_FFAB, RAM_MASK_B, 1'b0, 0, 32'h0, 1'b0, 4+L, 1, 1, 3+L, 16'd4, 32'h1122_AB44);
            xfer("lw_10",  1'b0, 18'h10, 32'h0, RAM_MASK_W, 1'b0, 0, 32'h1122_AB44, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);

            xfer("sw_20",  1'b1, 18'h20, 32'hDEAD_BEEF, RAM_MASK_W, 1'b0, 0, 32'h0, 1'b0, 2, 0, 1, 1, 16'd8, 32'hDEAD_BEEF);
            xfer("lw_20",  1'b0, 18'h20, 32'h0, RAM_MASK_W, 1'b0, 0, 32'hDEAD_BEEF, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);

            xfer("lw_02",  1'b0, 18'h02, 32'h0, RAM_MASK_W, 1'b0, 0, 32'h0, 1'b1, 1, 0, 0, -1, 16'd0, 32'h0);
            xfer("sh_03",  1'b1, 18'h03, 32'h0000_1234, RAM_MASK_H, 1'b0, 0, 32'h0, 1'b1, 1, 0, 0, -1, 16'd0, 32'h0);

            xfer("lh_22_bp", 1'b0, 18'h22, 32'h0, RAM_MASK_H, 1'b0, 5, 32'hFFFF_DEAD, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);

            @(negedge clk);
            req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h20; req_wdata = 32'h0000_0055;
            req_mask = RAM_MASK_B; req_unsigned = 1'b0;
            @(posedge clk);
            #1 req_valid = 1'b0;
            @(posedge clk);
            #2 rst_n = 1'b0;
            #1 chk_reset("reset_wait");
            @(negedge clk);
            rst_n = 1'b1;
            nwe = 0;
            for (int c = 0; c < 8; c++) begin
                @(negedge clk);
                if (cur_ram_we) nwe++;
            end
            chk("reset_wait.no_we", 32'(nwe), 32'd0);
            xfer("lbu_20", 1'b0, 18'h20, 32'h0, RAM_MASK_B, 1'b1, 0, 32'h0000_00EF, 1'b0, 3+L, 1, 0, -1, 16'd0, 32'h0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
